stage_tracker: RTL and testbench
================================

STAGE_TRACKER -- requirements
Module: stage_tracker

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 Parameter BUB_W, default 16, width of the saturating bubble counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 f_valid  input  1  fetch stage holds a valid instruction this cycle.
REQ-006 d_rs1, d_rs2, d_rd  input  5 each  register indices decoded in D stage.
REQ-007 d_reg_write  input  1  D-stage instruction writes the register file.
REQ-008 d_result_src  input  2  D-stage result source; bit0 = load.
REQ-009 e_pc_src  input  1  E-stage taken branch/jump; also drives flush accounting.
REQ-010 d_stall, d_flush, e_flush  input  1 each  hazard-unit controls.
REQ-011 d_valid  output  1  F/D stage valid bit.
REQ-012 e_rs1, e_rs2, e_rd  output  5 each  D/E register contents.
REQ-013 e_result_src  output  2  D/E result source.
REQ-014 m_rd, w_rd  output  5 each  E/M and M/W destination indices.
REQ-015 m_reg_write, w_reg_write  output  1 each  qualified write enables (valid AND reg_write).
REQ-016 e_valid, m_valid, w_valid  output  1 each  stage valid bits.
REQ-017 instret  output  CNT_W  count of instructions retired from W.
REQ-018 bubbles  output  BUB_W  saturating count of cycles with e_flush asserted.

Function
REQ-019 The F/D valid bit SHALL clear on d_flush, else hold on d_stall, else load f_valid (d_flush has priority over d_stall).
REQ-020 The D/E register SHALL load a bubble (valid=0, rs1=rs2=rd=0, reg_write=0, result_src=0) when e_flush=1, else capture d_valid and the d_* fields.
REQ-021 When d_valid=0 and e_flush=0, the D/E register SHALL capture valid=0 with reg_write and result_src forced to 0; index fields MAY be captured.
REQ-022 The E/M and M/W registers SHALL advance every cycle unconditionally (no stall input at those stages).
REQ-023 m_reg_write and w_reg_write SHALL be 0 whenever the corresponding valid bit is 0.
REQ-024 e_result_src SHALL equal 0 whenever e_valid=0 so no load-use stall arises from a bubble.
REQ-025 Latency: a D-stage instruction SHALL appear in E 1 cycle, M 2 cycles, W 3 cycles after capture, absent flushes.
REQ-026 instret SHALL increment by 1 on each rising edge where w_valid=1; wraps modulo 2^CNT_W.
REQ-027 bubbles SHALL increment on each rising edge where e_flush=1 and SHALL saturate at all-ones.
REQ-028 Simultaneous d_stall=1 and e_flush=1 (load-use) SHALL hold d_valid and insert one E bubble; the stalled instruction enters E on the next non-stalled cycle.
REQ-029 Simultaneous d_flush=1 and e_flush=1 (taken branch) SHALL invalidate both D and the next E; the instruction in M is unaffected.
REQ-030 e_pc_src SHALL have no direct state effect beyond what the hazard unit drives on d_flush/e_flush.
REQ-031 All outputs SHALL be registered except m_reg_write, w_reg_write (AND of registered bits).

Reset
REQ-032 While reset=1, all valid bits, indices, result_src, reg_write bits, instret and bubbles SHALL be 0, asynchronously.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight instructions; no retirement is counted in the reset cycle.
REQ-034 After reset deassertion the first f_valid=1 instruction SHALL reach w_valid=1 after 4 rising edges.

Verification
REQ-035 Straight line: f_valid=1 for 10 cycles, rd=1..10, reg_write=1 -> w_rd sequence 1..10 with w_reg_write=1, instret=10.
REQ-036 Load-use: load rd=5 in E, D instruction rs1=5, hazard drives d_stall=e_flush=1 one cycle -> e_valid=0 next cycle, dependent instruction in E the cycle after, bubbles=1.
REQ-037 Branch: e_pc_src with d_flush=e_flush=1 one cycle -> d_valid=0 and e_valid=0 next cycle, 2 instructions never retire, instret short by 2.
REQ-038 Bubble saturation with BUB_W=4: e_flush=1 for 20 cycles -> bubbles=15, no wrap.
REQ-039 Reset mid-stream: reset pulsed while e/m/w all valid -> all valids 0 immediately, instret=0, m_reg_write=w_reg_write=0.
REQ-040 instret wrap with CNT_W=4: 17 retirements -> instret=1.

Source files
------------

// File: rtl/stage_tracker.sv
// Pipeline occupancy tracker: mirrors the valid/index/control bits of a 5-stage
// in-order pipeline and counts retirements and E-stage bubbles.
module stage_tracker #(
  parameter int CNT_W = 32,
  parameter int BUB_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_valid,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic [4:0]       d_rd,
  input  logic             d_reg_write,
  input  logic [1:0]       d_result_src,
  input  logic             e_pc_src,
  input  logic             d_stall,
  input  logic             d_flush,
  input  logic             e_flush,
  output logic             d_valid,
  output logic [4:0]       e_rs1,
  output logic [4:0]       e_rs2,
  output logic [4:0]       e_rd,
  output logic [1:0]       e_result_src,
  output logic [4:0]       m_rd,
  output logic [4:0]       w_rd,
  output logic             m_reg_write,
  output logic             w_reg_write,
  output logic             e_valid,
  output logic             m_valid,
  output logic             w_valid,
  output logic [CNT_W-1:0] instret,
  output logic [BUB_W-1:0] bubbles
);

  logic e_reg_write_q;
  logic m_reg_write_q;
  logic w_reg_write_q;

  // Branch redirect is visible here only through d_flush/e_flush.
  logic unused_pc_src;
  assign unused_pc_src = e_pc_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_valid <= 1'b0;
    end else if (d_flush) begin
      d_valid <= 1'b0;
    end else if (!d_stall) begin
      d_valid <= f_valid;
    end
  end

  // Control bits are qualified by d_valid so a bubble never looks like a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid       <= 1'b0;
      e_rs1         <= '0;
      e_rs2         <= '0;
      e_rd          <= '0;
      e_reg_write_q <= 1'b0;
      e_result_src  <= '0;
    end else if (e_flush) begin
      e_valid       <= 1'b0;
      e_rs1         <= '0;
      e_rs2         <= '0;
      e_rd          <= '0;
      e_reg_write_q <= 1'b0;
      e_result_src  <= '0;
    end else begin
      e_valid       <= d_valid;
      e_rs1         <= d_rs1;
      e_rs2         <= d_rs2;
      e_rd          <= d_rd;
      e_reg_write_q <= d_valid & d_reg_write;
      e_result_src  <= d_valid ? d_result_src : 2'b00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid       <= 1'b0;
      m_rd          <= '0;
      m_reg_write_q <= 1'b0;
      w_valid       <= 1'b0;
      w_rd          <= '0;
      w_reg_write_q <= 1'b0;
    end else begin
      m_valid       <= e_valid;
      m_rd          <= e_rd;
      m_reg_write_q <= e_reg_write_q;
      w_valid       <= m_valid;
      w_rd          <= m_rd;
      w_reg_write_q <= m_reg_write_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
      bubbles <= '0;
    end else begin
      if (w_valid) instret <= instret + 1'b1;
      if (e_flush && (bubbles != {BUB_W{1'b1}})) bubbles <= bubbles + 1'b1;
    end
  end

  assign m_reg_write = m_valid & m_reg_write_q;
  assign w_reg_write = w_valid & w_reg_write_q;

endmodule

// File: tb/tb_stage_tracker.sv
// Directed bench for stage_tracker: straight line, load-use, branch, bubble
// saturation, mid-stream reset and retirement counter wrap (4-bit counters).
module tb_stage_tracker;
  localparam int CNT_W = 4;
  localparam int BUB_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             f_valid = 1'b0;
  logic [4:0]       d_rs1 = '0, d_rs2 = '0, d_rd = '0;
  logic             d_reg_write = 1'b0;
  logic [1:0]       d_result_src = '0;
  logic             e_pc_src = 1'b0;
  logic             d_stall = 1'b0, d_flush = 1'b0, e_flush = 1'b0;
  logic             d_valid;
  logic [4:0]       e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic [1:0]       e_result_src;
  logic             m_reg_write, w_reg_write;
  logic             e_valid, m_valid, w_valid;
  logic [CNT_W-1:0] instret;
  logic [BUB_W-1:0] bubbles;

  int total = 0;
  int passed = 0;

  stage_tracker #(.CNT_W(CNT_W), .BUB_W(BUB_W)) dut (
    .clk(clk), .reset(reset), .f_valid(f_valid),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_reg_write(d_reg_write), .d_result_src(d_result_src),
    .e_pc_src(e_pc_src), .d_stall(d_stall), .d_flush(d_flush), .e_flush(e_flush),
    .d_valid(d_valid), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_result_src(e_result_src), .m_rd(m_rd), .w_rd(w_rd),
    .m_reg_write(m_reg_write), .w_reg_write(w_reg_write),
    .e_valid(e_valid), .m_valid(m_valid), .w_valid(w_valid),
    .instret(instret), .bubbles(bubbles)
  );

  // clock
  always #5 clk = ~clk;

  // One rising edge, then settle before inputs change or outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    f_valid = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_reg_write = 0;
    d_result_src = 0; e_pc_src = 0; d_stall = 0; d_flush = 0; e_flush = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    // async reset before any clock edge
    #1 reset = 1;
    #1;
    chk("rst_d_valid", d_valid, 0);
    chk("rst_e_valid", e_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_instret", instret, 0);
    chk("rst_bubbles", bubbles, 0);
    do_reset();

    // straight line: 10 instructions rd=1..10
    d_reg_write = 1;
    for (int c = 0; c <= 14; c++) begin
      f_valid = (c < 10);
      d_rd = 5'(c);
      step();
      if (c < 3) chk("sl_w_valid_lat", w_valid, 0);
      if (c >= 3 && c <= 12) begin
        chk("sl_w_valid", w_valid, 1);
        chk("sl_w_rd", w_rd, c - 2);
        chk("sl_w_reg_write", w_reg_write, 1);
      end
    end
    chk("sl_w_valid_drained", w_valid, 0);
    chk("sl_instret", instret, 10);

    // load-use
    do_reset();
    f_valid = 1;
    step();
    d_rd = 5; d_result_src = 2'b01; d_reg_write = 1;
    step();
    chk("lu_e_result_src_load", e_result_src, 1);
    d_rs1 = 5; d_rd = 6; d_result_src = 2'b00;
    d_stall = 1; e_flush = 1;
    step();
    chk("lu_e_valid_bubble", e_valid, 0);
    chk("lu_e_result_src_bubble", e_result_src, 0);
    chk("lu_d_valid_held", d_valid, 1);
    chk("lu_m_rd", m_rd, 5);
    chk("lu_bubbles", bubbles, 1);
    d_stall = 0; e_flush = 0; f_valid = 0;
    step();
    chk("lu_e_valid_dep", e_valid, 1);
    chk("lu_e_rs1_dep", e_rs1, 5);
    chk("lu_e_rd_dep", e_rd, 6);
    chk("lu_w_rd_load", w_rd, 5);
    chk("lu_m_reg_write_bubble", m_reg_write, 0);

    // taken branch at cycle 3
    do_reset();
    d_reg_write = 1;
    for (int c = 0; c <= 11; c++) begin
      f_valid = (c <= 5);
      d_rd = 5'(c);
      d_flush = (c == 3);
      e_flush = (c == 3);
      e_pc_src = (c == 3);
      step();
      if (c == 3) begin
        chk("br_d_valid", d_valid, 0);
        chk("br_e_valid", e_valid, 0);
        chk("br_m_valid", m_valid, 1);
        chk("br_m_rd", m_rd, 2);
      end
    end
    chk("br_instret", instret, 4);
    chk("br_bubbles", bubbles, 1);

    // invalid D instruction carries no write/load
    do_reset();
    d_reg_write = 1; d_result_src = 2'b11; d_rd = 9;
    step();
    chk("inv_e_valid", e_valid, 0);
    chk("inv_e_result_src", e_result_src, 0);
    step();
    chk("inv_m_reg_write", m_reg_write, 0);

    // bubble saturation
    do_reset();
    e_flush = 1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 14) chk("sat_bubbles_14", bubbles, 14);
    end
    chk("sat_bubbles_20", bubbles, 15);
    e_flush = 0;

    // mid-stream reset
    do_reset();
    f_valid = 1; d_reg_write = 1; d_rd = 3;
    repeat (4) step();
    chk("mr_pre_w_valid", w_valid, 1);
    chk("mr_pre_w_reg_write", w_reg_write, 1);
    #2 reset = 1;
    #1;
    chk("mr_d_valid", d_valid, 0);
    chk("mr_e_valid", e_valid, 0);
    chk("mr_m_valid", m_valid, 0);
    chk("mr_w_valid", w_valid, 0);
    chk("mr_instret", instret, 0);
    chk("mr_m_reg_write", m_reg_write, 0);
    chk("mr_w_reg_write", w_reg_write, 0);
    step();
    chk("mr_hold_instret", instret, 0);
    chk("mr_hold_w_rd", w_rd, 0);
    reset = 0;

    // flush beats stall in F/D, then counter wrap after 17 retirements
    do_reset();
    f_valid = 1;
    step();
    d_flush = 1; d_stall = 1;
    step();
    chk("pri_d_valid", d_valid, 0);
    do_reset();
    d_reg_write = 1;
    for (int c = 0; c <= 22; c++) begin
      f_valid = (c <= 16);
      step();
    end
    chk("wrap_instret", instret, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
